// File: rtl/divider_4bits_seq.sv
// divider_4bits_seq: sequential unsigned restoring divider, one quotient bit per clock
// Build option DIV_ZERO_FASTPATH_EN: a zero divisor skips the iterations and finishes in one step.
module divider_4bits_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
`ifdef DIV_ZERO_FASTPATH_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nxt;
   logic [WIDTH-1:0] rem, rem_nxt, sh, sh_nxt, dvs;
   logic [WIDTH:0] shifted;
   logic [CW-1:0] cnt;
   logic zf, neg, last, accept;
   assign shifted = {rem, sh[WIDTH-1]};
   assign neg = shifted < {1'b0, dvs};
   assign rem_nxt = neg ? shifted[WIDTH-1:0] : shifted[WIDTH-1:0] - dvs;
   assign sh_nxt = (sh << 1) | WIDTH'(!neg);
   assign last = zf || cnt == CW'(1);
   assign accept = start && state != RUN;
   assign busy = state == RUN && !zf;
   assign done = state == DONE;
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   end
   // next state: iterate until the counter runs out, DONE always lasts one cycle
   always_comb begin
      nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
   end
   // datapath: capture on accept, one restoring step per RUN cycle, results loaded on the last step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
         sh <= '0;
         dvs <= '0;
         cnt <= '0;
         zf <= 1'b0;
         quotient <= '0;
         remainder <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         rem <= '0;
         sh <= dividend;
         dvs <= divisor;
         cnt <= CW'(WIDTH);
         zf <= FAST && divisor == '0;
         div_by_zero <= 1'b0;
      end else if (state == RUN) begin
         rem <= rem_nxt;
         sh <= sh_nxt;
         cnt <= cnt - CW'(1);
         if (last) begin
            quotient <= zf ? '1 : sh_nxt;
            remainder <= zf ? sh : rem_nxt;
            div_by_zero <= dvs == '0;
         end
      end
   end
endmodule

// File: tb/tb_divider_4bits_seq.sv
// tb_divider_4bits_seq: directed and random checks of the sequential divider against an arithmetic model
module tb_divider_4bits_seq;
`ifdef DIV_ZERO_FASTPATH_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [3:0] dividend = '0, divisor = '0;
   logic busy, done, div_by_zero;
   logic [3:0] quotient, remainder;
   logic [3:0] prev_q = '0, prev_r = '0;
   int compared = 0, mismatched = 0;

   divider_4bits_seq #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // called at a negedge; inj pokes a 9/2 start mid-run, chg zeroes the operands right after accept
   task automatic run(input logic [3:0] a, input logic [3:0] b, input bit inj, input bit chg);
      int lat = 0, bc = 0;
      bit got = 1'b0;
      bit zero = b == 4'd0;
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk);
      #1 start = 1'b0;
      if (chg) begin dividend = 4'd0; divisor = 4'd0; end
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk("hold_q", quotient, prev_q);
            chk("hold_r", remainder, prev_r);
            chk("dz_clear", div_by_zero, 0);
         end
         if (inj && lat == 2) begin start = 1'b1; dividend = 4'd9; divisor = 4'd2; end
         if (inj && lat == 3) start = 1'b0;
         bc += int'(busy);
         got = done;
      end
      chk("latency", got ? lat : -1, (FAST && zero) ? 2 : 5);
      chk("busy_cycles", bc, (FAST && zero) ? 0 : 4);
      chk("quotient", quotient, zero ? 15 : a / b);
      chk("remainder", remainder, zero ? int'(a) : a % b);
      chk("div_by_zero", div_by_zero, int'(zero));
      prev_q = zero ? 4'd15 : a / b;
      prev_r = zero ? a : a % b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_done", done, 0);
         chk("idle_busy", busy, 0);
         chk("idle_q", quotient, prev_q);
         chk("idle_r", remainder, prev_r);
      end
   endtask

   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dz", div_by_zero, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      run(4'd6, 4'd3, 1'b0, 1'b0);
      idle(2);
      run(4'd10, 4'd3, 1'b0, 1'b0);
      run(4'd13, 4'd10, 1'b0, 1'b0);
      run(4'd15, 4'd1, 1'b0, 1'b0);
      run(4'd3, 4'd13, 1'b0, 1'b0);
      idle(2);
      run(4'd13, 4'd10, 1'b1, 1'b0);
      idle(8);
      run(4'd14, 4'd4, 1'b0, 1'b1);
      run(4'd7, 4'd0, 1'b0, 1'b0);
      idle(1);
      start = 1'b1; dividend = 4'd11; divisor = 4'd3;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_q", quotient, 0);
      chk("async_r", remainder, 0);
      chk("async_dz", div_by_zero, 0);
      prev_q = 4'd0; prev_r = 4'd0;
      @(negedge clk) rst_n = 1'b1;
      idle(6);
      run(4'd12, 4'd5, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++)
         run(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'b0, 1'b0);
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
